// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the PC sequencer and its return-address stack.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_SRC_RESET,
    PC_SRC_JUMP,
    PC_SRC_CALL,
    PC_SRC_RET,
    PC_SRC_HOLD,
    PC_SRC_INC
  } pc_src_t;

  // Enough bits to count 0..depth valid entries.
  function automatic int unsigned ras_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular LIFO return-address stack; a push while full overwrites the oldest entry.
module pc_ras_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned RAS_DEPTH  = 4,
  localparam int unsigned CntW      = ras_cnt_width(RAS_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  output logic [PC_WIDTH-1:0] top_data_o,
  output logic [CntW-1:0]     count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(RAS_DEPTH - 1);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CntW-1:0]     count_q, count_d;

  // wr_ptr_q is the next slot to write; the top of stack sits just below it.
  assign top_ptr = (wr_ptr_q == '0) ? LastIdx : wr_ptr_q - PtrW'(1);
  assign full_o  = (count_q == CntW'(RAS_DEPTH));
  assign empty_o = (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
      count_d  = full_o ? count_q : count_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign top_data_o = mem_q[top_ptr];
  assign count_o    = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with stall, jump, call/return via RAS and a one-cycle flush pulse.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RAS_DEPTH  = 4,
  localparam int unsigned CntW      = ras_cnt_width(RAS_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                jump_i,
  input  logic                call_i,
  input  logic                ret_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                flush_o,
  output logic [CntW-1:0]     ras_count_o,
  output logic                ras_overflow_o,
  output logic                ras_underflow_o
);

  localparam logic [PC_WIDTH-1:0] ResetPc = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] Step    = PC_WIDTH'(STEP);

  pc_src_t             pc_src;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic                flush_q, flush_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                ras_full, ras_empty, ret_empty;
  logic [CntW-1:0]     ras_count;

  assign pc_inc = pc_q + Step;

  // An empty-stack return falls through to the stall/increment rule.
  always_comb begin
    ret_empty = 1'b0;
    if (reset)                       pc_src = PC_SRC_RESET;
    else if (jump_i)                 pc_src = PC_SRC_JUMP;
    else if (call_i)                 pc_src = PC_SRC_CALL;
    else if (ret_i && !ras_empty)    pc_src = PC_SRC_RET;
    else begin
      ret_empty = ret_i;
      pc_src    = stall_i ? PC_SRC_HOLD : PC_SRC_INC;
    end
  end

  pc_ras_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (pc_src == PC_SRC_CALL),
    .pop_i       (pc_src == PC_SRC_RET),
    .push_data_i (pc_inc),
    .top_data_o  (ras_top),
    .count_o     (ras_count),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q | ret_empty;
    unique case (pc_src)
      PC_SRC_RESET: begin
        pc_d  = ResetPc;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      PC_SRC_JUMP: begin
        pc_d    = jump_target_i;
        flush_d = 1'b1;
      end
      PC_SRC_CALL: begin
        pc_d    = jump_target_i;
        flush_d = 1'b1;
        ovf_d   = ovf_q | ras_full;
      end
      PC_SRC_RET: begin
        pc_d    = ras_top;
        flush_d = 1'b1;
      end
      PC_SRC_HOLD: pc_d = pc_q;
      PC_SRC_INC:  pc_d = pc_inc;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    flush_q <= flush_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  always_comb begin
    pc_o            = pc_q;
    flush_o         = flush_q;
    ras_count_o     = ras_count;
    ras_overflow_o  = ovf_q;
    ras_underflow_o = unf_q;
  end

endmodule
